uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx_8n1 transmitter between N byte requesters (echo path, FFT result path, status).
//  Round-robin grant; sequences the senddata pulse and tracks the tx busy flag.
//  Optional per-requester lock keeps the grant for back-to-back bytes of one packet.
//  Sits between the requesters and uart_tx_8n1 in the top level, on the 12 MHz hwclk.
// PARAMETERS
//  N_REQ          4    number of requesters, 2..8
//  START_TIMEOUT  16   cycles to wait for tx_busy to rise after tx_send before aborting
// PORTS
//  hwclk          in   1        system clock (12 MHz)
//  rst            in   1        asynchronous, active-high reset
//  req_valid      in   N_REQ    requester i has a byte on req_data[8*i+:8]
//  req_data       in   8*N_REQ  packed request bytes
//  req_lock       in   N_REQ    keep grant after this byte while req_valid[i] stays high
//  req_ready      out  N_REQ    one-cycle accept pulse; byte i latched this cycle
//  tx_byte        out  8        to uart_tx_8n1 txbyte
//  tx_send        out  1        to uart_tx_8n1 senddata, one-cycle pulse
//  tx_busy        in   1        from uart_tx_8n1 busy
//  grant_id       out  3        index of current/last granted requester
//  active         out  1        high from accept until tx_busy falls
//  err_timeout    out  1        one-cycle pulse: tx_busy never rose, byte dropped
// BEHAVIOUR
//  Reset: state IDLE, req_ready=0, tx_byte=8'h00, tx_send=0, grant_id=0, active=0,
//   err_timeout=0, rr pointer=0, lock=0. Reset mid-transfer abandons the byte, no err pulse.
//  States: IDLE -> SEND -> WAIT_START -> WAIT_DONE -> IDLE.
//  IDLE: if tx_busy==0 and any req_valid: pick winner w, pulse req_ready[w], latch
//   req_data[w] into tx_byte, grant_id<=w, active<=1, lock<=req_lock[w]; go SEND.
//   tx_busy==1 in IDLE (external send in progress) blocks all grants.
//  Winner: if lock set and req_valid[grant_id], w=grant_id; else first valid index scanning
//   ptr, ptr+1, ... mod N_REQ. Lock with req_valid[grant_id] low in IDLE clears lock, rr resumes.
//  Pointer update on every non-locked grant: ptr <= (w+1) mod N_REQ; locked grants leave ptr.
//  SEND: tx_send=1 for exactly this cycle, tx_byte stable; go WAIT_START, counter=0.
//  WAIT_START: tx_busy==1 -> WAIT_DONE. Else count; at START_TIMEOUT-1 pulse err_timeout,
//   active<=0, lock<=0, go IDLE.
//  WAIT_DONE: tx_busy==0 -> active<=0, go IDLE. No timeout (frame length fixed by tx).
//  Latency: req_valid with tx idle -> req_ready same... next edge (1 cycle); tx_send 1 cycle
//   after req_ready. Minimum 1 idle cycle between bytes.
//  tx_byte holds last value between transfers; requesters may change req_data after req_ready.
//  Simultaneous valid: only one req_ready bit ever high; others hold valid/data.
//  req_valid dropped without req_ready: legal, no effect.
// STRUCTURE
//  uart_pkg: state enum (IDLE,SEND,WAIT_START,WAIT_DONE), UART_BYTE_W=8, GRANT_W=3.
//  Sub-module rr_pick: combinational round-robin picker (valid, ptr, lock, lock_id -> w, any).
//  FSM, counter, latches in uart_tx_arbiter; instantiated beside uart_tx_8n1 in top.
// TESTING (bench models uart_tx_8n1 busy: rises 1 cycle after send, held 1250 cycles)
//  Single: req_valid[2]=1, data 8'hA5 -> req_ready[2] 1 cycle, tx_byte=A5, one tx_send, grant_id=2.
//  All 4 valid continuously, no lock -> grant order 0,1,2,3,0; exactly one send per busy frame.
//  req_lock[1]=1 on 3 bytes with req 0,3 valid -> 1,1,1 then 3,0 (ptr resumes at 2 -> 3).
//  Busy model never rises -> err_timeout pulse 16 cycles after tx_send, active=0, next grant ok.
//  rst asserted in WAIT_DONE -> all outputs at reset values immediately; ptr=0 after release.
//  tx_busy held high externally with req 0 valid -> no req_ready until busy falls.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// ------------------------------------------------------------------
// uart_tx_arbiter_pkg : shared types/widths for the UART tx arbiter
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package uart_tx_arbiter_pkg;

  localparam int UART_BYTE_W = 8;
  localparam int GRANT_W     = 3;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEND       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
// ------------------------------------------------------------------
// uart_tx_arbiter_if : requester bundle plus uart_tx_8n1 side signals
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) ();

  logic [N_REQ-1:0]             req_valid;
  logic [UART_BYTE_W*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]             req_lock;
  logic [N_REQ-1:0]             req_ready;
  logic [UART_BYTE_W-1:0]       tx_byte;
  logic                         tx_send;
  logic                         tx_busy;
  logic [GRANT_W-1:0]           grant_id;
  logic                         active;
  logic                         err_timeout;

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, req_lock, tx_busy,
    output req_ready, tx_byte, tx_send, grant_id, active, err_timeout
  );

  // Requesters plus transmitter side.
  modport master (
    output req_valid, req_data, req_lock, tx_busy,
    input  req_ready, tx_byte, tx_send, grant_id, active, err_timeout
  );

endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ------------------------------------------------------------------
// rr_pick : combinational round-robin picker with sticky lock owner
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]   valid,
  input  logic [GRANT_W-1:0] ptr,
  input  logic               lock,
  input  logic [GRANT_W-1:0] lock_id,
  output logic [GRANT_W-1:0] w,
  output logic               any,
  output logic               hold
);

  always_comb begin
    w    = '0;
    any  = 1'b0;
    hold = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (lock && valid[j] && (lock_id == GRANT_W'(j))) hold = 1'b1;
    end
    if (hold) begin
      w   = lock_id;
      any = 1'b1;
    end else begin
      // Walk offsets from the far end so the closest one to ptr wins last.
      for (int k = N_REQ - 1; k >= 0; k--) begin
        for (int j = 0; j < N_REQ; j++) begin
          if (valid[j] && ((int'(ptr) + k == j) || (int'(ptr) + k == j + N_REQ))) begin
            w   = GRANT_W'(j);
            any = 1'b1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ------------------------------------------------------------------
// uart_tx_arbiter : shares one uart_tx_8n1 between N_REQ byte sources
// rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int START_TIMEOUT = 16
) (
  input  wire               hwclk,
  input  wire               rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int CNT_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  arb_state_e             state_q, state_d;
  logic [N_REQ-1:0]       req_ready_q, req_ready_d;
  logic [UART_BYTE_W-1:0] tx_byte_q, tx_byte_d;
  logic                   tx_send_q, tx_send_d;
  logic [GRANT_W-1:0]     grant_q, grant_d;
  logic                   active_q, active_d;
  logic                   err_q, err_d;
  logic [GRANT_W-1:0]     ptr_q, ptr_d;
  logic                   lock_q, lock_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [GRANT_W-1:0]     win_id;
  logic                   win_any;
  logic                   win_hold;
  logic [UART_BYTE_W-1:0] sel_byte;
  logic                   sel_lock;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .valid   (bus.req_valid),
    .ptr     (ptr_q),
    .lock    (lock_q),
    .lock_id (grant_q),
    .w       (win_id),
    .any     (win_any),
    .hold    (win_hold)
  );

  always_comb begin
    sel_byte = '0;
    sel_lock = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win_id == GRANT_W'(k)) begin
        sel_byte = bus.req_data[UART_BYTE_W*k +: UART_BYTE_W];
        sel_lock = bus.req_lock[k];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_d = '0;
    tx_byte_d   = tx_byte_q;
    tx_send_d   = 1'b0;
    grant_d     = grant_q;
    active_d    = active_q;
    err_d       = 1'b0;
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        // A busy transmitter here means someone else owns it; grant nothing.
        if (!bus.tx_busy && win_any) begin
          req_ready_d = N_REQ'(1) << win_id;
          tx_byte_d   = sel_byte;
          grant_d     = win_id;
          active_d    = 1'b1;
          lock_d      = sel_lock;
          if (!win_hold) begin
            ptr_d = (win_id == GRANT_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
          end
          state_d = SEND;
        end else if (lock_q && !win_hold) begin
          lock_d = 1'b0;
        end
      end
      SEND: begin
        tx_send_d = 1'b1;
        cnt_d     = '0;
        state_d   = WAIT_START;
      end
      WAIT_START: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          err_d    = 1'b1;
          active_d = 1'b0;
          lock_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_ready_q <= '0;
      tx_byte_q   <= '0;
      tx_send_q   <= 1'b0;
      grant_q     <= '0;
      active_q    <= 1'b0;
      err_q       <= 1'b0;
      ptr_q       <= '0;
      lock_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      tx_byte_q   <= tx_byte_d;
      tx_send_q   <= tx_send_d;
      grant_q     <= grant_d;
      active_q    <= active_d;
      err_q       <= err_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.tx_byte     = tx_byte_q;
  assign bus.tx_send     = tx_send_q;
  assign bus.grant_id    = grant_q;
  assign bus.active      = active_q;
  assign bus.err_timeout = err_q;

endmodule

`default_nettype wire
